// File: rtl/s_o_symbol_gen.sv
// Symbol execution stage: plays an S (three short pulses) or O (three long pulses) on pin_out,
// then returns a one-cycle func_done and waits for the request to be withdrawn.
module s_o_symbol_gen #(
  parameter int unsigned SHORT_CYC = 5_000_000,
  parameter int unsigned LONG_CYC  = 15_000_000,
  parameter int unsigned GAP_CYC   = 5_000_000,
  parameter int unsigned PULSES    = 3,
  parameter int unsigned CNT_W     = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] func_start,
  output logic       func_done,
  output logic       pin_out,
  output logic       busy
);

  localparam int unsigned PCNT_W = (PULSES > 1) ? $clog2(PULSES) : 1;

  localparam logic [CNT_W-1:0]  ShortLim  = CNT_W'(SHORT_CYC - 1);
  localparam logic [CNT_W-1:0]  LongLim   = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0]  GapLim    = CNT_W'(GAP_CYC - 1);
  localparam logic [PCNT_W-1:0] LastPulse = PCNT_W'(PULSES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StOn,
    StOff,
    StDone,
    StRearm
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [PCNT_W-1:0]   pcnt_q;
  logic                sym_q;    // 0: S (short), 1: O (long)
  logic [CNT_W-1:0]    on_lim;
  logic                req_valid;

  assign on_lim    = sym_q ? LongLim : ShortLim;
  // Only 10 and 01 are real requests; 11 is illegal and ignored.
  assign req_valid = (func_start == 2'b10) || (func_start == 2'b01);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pcnt_q    <= '0;
      sym_q     <= 1'b0;
      pin_out   <= 1'b0;
      busy      <= 1'b0;
      func_done <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            sym_q   <= func_start[0];
            cnt_q   <= '0;
            pcnt_q  <= '0;
            pin_out <= 1'b1;
            busy    <= 1'b1;
            state_q <= StOn;
          end
        end
        StOn: begin
          if (cnt_q == on_lim) begin
            cnt_q   <= '0;
            pin_out <= 1'b0;
            state_q <= StOff;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StOff: begin
          if (cnt_q == GapLim) begin
            cnt_q <= '0;
            if (pcnt_q != LastPulse) begin
              pcnt_q  <= pcnt_q + PCNT_W'(1);
              pin_out <= 1'b1;
              state_q <= StOn;
            end else begin
              func_done <= 1'b1;
              state_q   <= StDone;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StDone: begin
          func_done <= 1'b0;
          busy      <= 1'b0;
          state_q   <= StRearm;
        end
        StRearm: begin
          // A still-held request must not replay the symbol.
          if (func_start == 2'b00) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/s_o_symbol_gen.md
Name: s_o_symbol_gen

Overview:
- Symbol execution stage that sits directly downstream of the S/O command sequencer.
- Accepts a held symbol request on func_start: 2'b10 = S (three short pulses), 2'b01 = O (three long pulses).
- Drives the indicator output (LED/buzzer) with the pulse train, then returns a one-cycle func_done.
- The sequencer holds func_start until it sees func_done, then drops func_start to 2'b00 for at least one cycle.

Parameters:
SHORT_CYC, 5_000_000, high time of one S pulse in clk cycles (100 ms at 50 MHz)
LONG_CYC, 15_000_000, high time of one O pulse in clk cycles (300 ms at 50 MHz)
GAP_CYC, 5_000_000, low time after every pulse in clk cycles, including after the last pulse
PULSES, 3, pulses per symbol
CNT_W, 24, duration counter width; must hold max(SHORT_CYC, LONG_CYC, GAP_CYC)-1

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
func_start  input  2  symbol request, level, held by requester: 10=S, 01=O, 00/11=no request
func_done  output  1  one-cycle pulse: symbol complete
pin_out  output  1  indicator drive, active-high, registered
busy  output  1  high from acceptance until the func_done cycle inclusive

Behaviour:
- Clock and reset: reset rst_n, asynchronous, active-low; clock clk. All state is registered on posedge clk.
- Reset values: func_done=0, pin_out=0, busy=0, state=IDLE, duration counter=0, pulse counter=0, latched symbol=0.
- Reset asserted mid-symbol: outputs go to reset values immediately (asynchronously). There is no resume; after release the block waits in IDLE for a new request.
- IDLE:
  - func_start==10 or 01 at edge k: latch type (S selects SHORT_CYC, O selects LONG_CYC), pulse count=0, duration counter=0, enter ON, pin_out<=1, busy<=1.
  - func_start==00 or 11: stay IDLE. 11 is illegal and is ignored with no response.
- ON: pin_out high for exactly the latched on-time in cycles (k+1 .. k+ON). On the last on-cycle: duration counter=0, pin_out<=0, enter OFF.
- OFF: pin_out low for exactly GAP_CYC cycles. On the last gap cycle:
  - If pulse count < PULSES-1: increment pulse count, pin_out<=1, enter ON.
  - Otherwise enter DONE.
- DONE: func_done=1 and busy=1 for exactly one cycle, at cycle k+1+PULSES*(ON+GAP). Then enter REARM with busy<=0.
- REARM: wait until func_start==00, then go to IDLE. A still-held request is never re-executed, so there is no double symbol even if the requester is slow to drop func_start.
- Requester behaviour: func_start is sampled only in IDLE. Changes or drops of func_start during ON/OFF/DONE are ignored; the latched symbol always completes.
- Latency: request accepted at edge k; first pulse_out high in cycle k+1; no pin_out glitch between consecutive pulses other than the GAP_CYC low time.
- Counters: the duration counter counts 0..limit-1 and resets on every state change; there is no wrap inside a state. Parameter values < 1 are not supported.

Test Plan:
(Bench parameters: SHORT_CYC=4, LONG_CYC=12, GAP_CYC=4, PULSES=3.)
- S request: func_start=10 sampled at edge k, held until func_done -> pin_out pattern (1x4, 0x4) three times over k+1..k+24; func_done high only in cycle k+25; busy high k+1..k+25.
- O request: func_start=01 at edge k -> pin_out (1x12, 0x4) x3 over k+1..k+48; func_done single cycle at k+49.
- Command-sequencer emulation, SOS: requester drives 10, 01, 10, clearing to 00 for one cycle after each func_done -> exactly 9 pulses, lengths 4,4,4,12,12,12,4,4,4; exactly three func_done pulses; no extra symbol.
- Held and illegal requests: func_start held at 10 for 60 cycles after func_done -> no new pulses and busy=0 until func_start returns to 00; func_start=11 for 20 cycles -> pin_out=0, busy=0, func_done=0.
- Mid-symbol changes: switch func_start from 10 to 01 during the second S pulse -> the S pattern completes unchanged with a single func_done at k+25.
- Reset mid-pulse: assert rst_n=0 during an O pulse -> pin_out, busy, func_done all 0 immediately; after release with func_start=10, a full S symbol runs starting one cycle after acceptance.
